// File: rtl/arm_pkg.sv
// ----------------------------------------------------------------------------
// arm_pkg
//   Shared types and constants for the ARM pipeline stages.
//   - INSTR_W      : instruction / PC width in bits
//   - fetch_entry_t: one {pc, instr} fetch record as passed from IF to ID
//   - NOP_INSTR    : instruction word presented to ID when nothing is valid
// ----------------------------------------------------------------------------
package arm_pkg;

  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'b0;

endpackage : arm_pkg

// File: rtl/if_id_fetch_queue.sv
// ----------------------------------------------------------------------------
// if_id_fetch_queue
//   Show-ahead fetch queue between the IF and ID stages. Buffers up to DEPTH
//   {PC, instruction} pairs, freezes IF when full, and discards everything on
//   a taken branch (wrong-path fetches).
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-low
//   if_valid   in   IF presents a fetch this cycle
//   if_pc      in   PC+4 value of the fetch
//   if_instr   in   fetched instruction word
//   if_freeze  out  queue full; freezes the IF stage
//   id_freeze  in   ID hazard stall; head entry is held
//   flush      in   branch taken; discard all entries
//   id_valid   out  head entry is valid
//   id_pc      out  head entry PC (0 when empty)
//   id_instr   out  head entry instruction (0 when empty)
//   count      out  number of occupied entries
// ----------------------------------------------------------------------------
module if_id_fetch_queue
  import arm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = INSTR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_valid,
  input  logic [WIDTH-1:0]           if_pc,
  input  logic [WIDTH-1:0]           if_instr,
  output logic                       if_freeze,
  input  logic                       id_freeze,
  input  logic                       flush,
  output logic                       id_valid,
  output logic [WIDTH-1:0]           id_pc,
  output logic [WIDTH-1:0]           id_instr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem_pc    [DEPTH];
  logic [WIDTH-1:0] r_mem_instr [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  // Full is decoded from the registered count only, so a pop in the same
  // cycle never opens the queue to a push and id_freeze has no path to IF.
  assign if_freeze = (r_count == FULL_CNT);
  assign id_valid  = (r_count != '0);

  assign w_push = if_valid & ~if_freeze & ~flush;
  assign w_pop  = id_valid & ~id_freeze & ~flush;

  // Show-ahead read mux; an empty queue presents zeros rather than stale data.
  assign id_pc    = id_valid ? r_mem_pc[r_rd_ptr]    : '0;
  assign id_instr = id_valid ? r_mem_instr[r_rd_ptr] : WIDTH'(NOP_INSTR);
  assign count    = r_count;

  // NOTE: the storage array sits in the reset branch on purpose: after reset
  // every entry must read as zero, so it is built from resettable flops
  // rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]    <= '0;
        r_mem_instr[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      // Branch taken: drop everything, including a same-cycle push or pop.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem_pc[r_wr_ptr]    <= if_pc;
        r_mem_instr[r_wr_ptr] <= if_instr;
        r_wr_ptr              <= r_wr_ptr + 1'b1;  // DEPTH is a power of two: wraps naturally
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : if_id_fetch_queue
